// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the core's single memory port between instruction fetch and the
// load/store path. One transaction is in flight at a time. Data requests win
// arbitration, but after MAX_D_STREAK back-to-back data grants with a fetch
// waiting, the fetch is granted next.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   if_req_* / if_rsp_*       fetch request (valid/addr/ready) and response
//   d_req_* / d_rsp_*         load/store request and response
//   mem_req_* / mem_rsp_*     registered request to memory, response back
//   protocol_err              sticky: response seen with nothing outstanding
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                d_req_valid,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_be,
    output logic                d_req_ready,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_rdata,
    output logic                mem_req_valid,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_be,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    output logic                protocol_err
);

    localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_owner;      // 0 = fetch, 1 = data
    logic [3:0]          r_streak;
    logic                r_err;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_be;

    logic w_grant_d, w_grant_f, w_rsp_if, w_rsp_d;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_f   = 1'b0;
        w_rsp_if    = 1'b0;
        w_rsp_d     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Data wins unless it has hit its streak limit while a fetch waits.
                if (d_req_valid && ((r_streak < MAX_S) || !if_req_valid))
                    w_grant_d = 1'b1;
                else if (if_req_valid)
                    w_grant_f = 1'b1;
                if (w_grant_d || w_grant_f)
                    w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (mem_req_ready)
                    w_state_nxt = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    w_rsp_if    = ~r_owner;
                    w_rsp_d     = r_owner;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_streak <= '0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_d) begin
                r_owner <= 1'b1;
                r_we    <= d_req_we;
                r_addr  <= d_req_addr;
                r_wdata <= d_req_wdata;
                r_be    <= d_req_be;
            end else if (w_grant_f) begin
                r_owner <= 1'b0;
                r_we    <= 1'b0;
                r_addr  <= if_req_addr;
                r_wdata <= '0;
                r_be    <= '1;
            end
            // The streak only counts data grants that made a fetch wait.
            if (w_grant_d && if_req_valid) begin
                if (r_streak < MAX_S)
                    r_streak <= r_streak + 4'd1;
            end else if (w_grant_d || w_grant_f) begin
                r_streak <= '0;
            end
            if (mem_rsp_valid && (r_state != S_WAIT_RSP))
                r_err <= 1'b1;
        end
    end

    // Handshake outputs are held low while reset is asserted.
    assign if_req_ready  = w_grant_f & ~rst;
    assign d_req_ready   = w_grant_d & ~rst;
    assign if_rsp_valid  = w_rsp_if & ~rst;
    assign d_rsp_valid   = w_rsp_d & ~rst;
    assign if_rsp_data   = mem_rsp_rdata;
    assign d_rsp_rdata   = mem_rsp_rdata;
    assign mem_req_valid = (r_state == S_REQ) & ~rst;
    assign mem_req_we    = r_we;
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;
    assign mem_req_be    = r_be;
    assign protocol_err  = r_err;

endmodule
